pipe_ctl: RTL and testbench
===========================

Name: pipe_ctl

Overview:
Pipeline control unit for the 5-stage Y86-64 processor. Sequences the F/D/E/M/W pipeline registers by generating their stall and bubble controls. Resolves load/use, ret and branch-mispredict hazards, and gates condition-code updates on exceptions. Adds a run/stop state machine that latches the final processor status, plus saturating performance counters.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse: IDLE->RUN, or STOP->IDLE
D_icode  input  4  icode in D register
d_srcA  input  4  decode srcA
d_srcB  input  4  decode srcB
E_icode  input  4  icode in E register
E_dstM  input  4  dstM in E register
e_Cnd  input  1  execute condition result
M_icode  input  4  icode in M register
m_stat  input  4  memory-stage status
W_stat  input  4  status in W register
W_icode  input  4  icode in W register
F_stall  output  1  hold F (PC prediction) register
D_stall  output  1  hold D register
D_bubble  output  1  load NOP/AOK into D
E_bubble  output  1  load NOP/AOK into E
M_bubble  output  1  load NOP/AOK into M
W_stall  output  1  hold W register
set_cc  output  1  enable CC write in execute
run_state  output  2  FSM state: 0 IDLE, 1 RUN, 2 STOP
proc_stat  output  4  latched final status
cycle_cnt  output  CNT_W  cycles spent in RUN
retire_cnt  output  CNT_W  instructions retired
stall_cnt  output  CNT_W  RUN cycles with F_stall=1
mispred_cnt  output  CNT_W  mispredicted jumps

Behaviour:
- Encodings: icodes HALT 0, NOP 1, MRMOVQ 5, OPQ 6, JXX 7, RET 9, POPQ B. Register RNONE F. Stat AOK 1, HLT 2, ADR 3, INS 4. exc(s) = s in {HLT, ADR, INS}.
- Hazard terms, combinational: loaduse = E_icode in {MRMOVQ, POPQ} && E_dstM != RNONE && E_dstM in {d_srcA, d_srcB}. ret_h = RET in {D_icode, E_icode, M_icode}. mispred = E_icode==JXX && !e_Cnd.
- RUN outputs:
  - F_stall = loaduse | ret_h
  - D_stall = loaduse
  - D_bubble = mispred | (ret_h & !loaduse)
  - E_bubble = mispred | loaduse
  - M_bubble = exc(m_stat) | exc(W_stat)
  - W_stall = exc(W_stat)
  - set_cc = E_icode==OPQ & !exc(m_stat) & !exc(W_stat)
- D_stall and D_bubble are never both 1. mispred and loaduse cannot both hold.
- IDLE outputs: F_stall=1, D_bubble=E_bubble=M_bubble=1, D_stall=0, W_stall=0, set_cc=0. This flushes the pipe with bubbles.
- STOP outputs: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0, set_cc=0. Architectural state is frozen.
- FSM, registered, reset to IDLE:
  - IDLE: start -> RUN, clearing all counters on that edge.
  - RUN: exc(W_stat) -> STOP, latching proc_stat<=W_stat on the same edge. start is ignored in RUN.
  - STOP: start -> IDLE, with proc_stat<=AOK. Counters hold their values.
- Counters, RUN only, saturating at all-ones:
  - cycle_cnt +1 every RUN cycle, including the transition cycle.
  - retire_cnt +1 when W_stat==AOK & W_icode!=NOP & !W_stall.
  - stall_cnt +1 when F_stall.
  - mispred_cnt +1 when mispred.
- Reset, asynchronous and active-high, at any time including mid-RUN: state IDLE, proc_stat=AOK, all counters 0. Stall/bubble outputs immediately take their IDLE values, since they decode from state.
- Latency: control outputs are 0-cycle combinational from the inputs and current state. run_state, proc_stat and the counters update 1 cycle after the qualifying condition.

Decomposition:
- Shared package y86_pkg holds the icode, register-id and stat constants and the run_state encoding. The pipeline registers reuse the same package.
- One natural sub-module, sat_counter (CNT_W, clear, inc), instantiated four times.

Test Plan:
- Reset, then start; RUN with E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt=1 next cycle.
- RUN, D_icode=9 with no load/use -> F_stall=1, D_bubble=1; RET moving to E then M -> bubbles for 3 consecutive cycles.
- RUN, E_icode=7, e_Cnd=0 -> D_bubble=E_bubble=1, F_stall=0; mispred_cnt increments by 1.
- RUN, m_stat=3 with E_icode=6 -> set_cc=0, M_bubble=1. Next cycle W_stat=3 -> W_stall=1, then state STOP, proc_stat=3, counters frozen.
- STOP, start pulse -> IDLE, proc_stat=1. Second start -> RUN with all counters reading 0 on the following cycle.
- Assert reset mid-RUN with cycle_cnt=10 -> immediately run_state=0, F_stall=1, cycle_cnt=0, without waiting for a clock edge.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, register ids, status codes, run-state encoding.
// Latency: n/a (constants, types and a pure helper function).
// Backpressure: n/a.
package y86_pkg;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [3:0] S_AOK    = 4'h1;
  localparam logic [3:0] S_HLT    = 4'h2;
  localparam logic [3:0] S_ADR    = 4'h3;
  localparam logic [3:0] S_INS    = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } run_state_t;

  // Any status that should end execution.
  function automatic logic is_exc(input logic [3:0] s);
    return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
// Latency: count reflects clear/inc one cycle after they are sampled.
// Backpressure: none; once at all-ones further increments are dropped.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear has priority; increment stops at all-ones instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctl.sv
// Y86-64 pipeline control: stall/bubble generation, run/stop FSM, perf counters.
// Latency: stall/bubble/set_cc are combinational; state, status and counters are 1 cycle.
// Backpressure: holds F/D (and W/everything in STOP) by stall, squashes by bubble.
module pipe_ctl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  input  logic [3:0]       W_icode,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic [1:0]       run_state,
  output logic [3:0]       proc_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  run_state_t state;
  logic       loaduse;
  logic       ret_h;
  logic       mispred;
  logic       m_exc;
  logic       w_exc;
  logic       in_run;
  logic       cnt_clr;

  // Hazard detection, independent of run state.
  always_comb begin
    loaduse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
              (E_dstM != R_NONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret_h   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mispred = (E_icode == I_JXX) && !e_Cnd;
    m_exc   = is_exc(m_stat);
    w_exc   = is_exc(W_stat);
  end

  // Pipeline register controls decoded from state; IDLE flushes, STOP freezes.
  always_comb begin
    F_stall  = 1'b1;
    D_stall  = 1'b0;
    D_bubble = 1'b1;
    E_bubble = 1'b1;
    M_bubble = 1'b1;
    W_stall  = 1'b0;
    set_cc   = 1'b0;
    case (state)
      ST_RUN: begin
        F_stall  = loaduse | ret_h;
        D_stall  = loaduse;
        D_bubble = mispred | (ret_h & ~loaduse);
        E_bubble = mispred | loaduse;
        M_bubble = m_exc | w_exc;
        W_stall  = w_exc;
        set_cc   = (E_icode == I_OPQ) & ~m_exc & ~w_exc;
      end
      ST_STOP: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
      end
      default: ;
    endcase
  end

  // Run/stop sequencing; final status is captured on the stopping edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      proc_stat <= S_AOK;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_RUN;
        ST_RUN: begin
          if (w_exc) begin
            state     <= ST_STOP;
            proc_stat <= W_stat;
          end
        end
        ST_STOP: begin
          if (start) begin
            state     <= ST_IDLE;
            proc_stat <= S_AOK;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign run_state = state;
  assign in_run    = (state == ST_RUN);
  assign cnt_clr   = (state == ST_IDLE) & start;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clr),
    .inc   (in_run),
    .count (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clr),
    .inc   (in_run & (W_stat == S_AOK) & (W_icode != I_NOP) & ~W_stall),
    .count (retire_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clr),
    .inc   (in_run & F_stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clr),
    .inc   (in_run & mispred),
    .count (mispred_cnt)
  );

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed bench for pipe_ctl: hazards, run/stop sequencing, counters, async reset.
// Latency: inputs driven at negedge, combinational checks #1 later, registered at next negedge.
// Backpressure: n/a.
module tb_pipe_ctl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic        e_Cnd;
  logic [3:0]  m_stat, W_stat, W_icode;
  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
  logic [1:0]  run_state;
  logic [3:0]  proc_stat;
  logic [31:0] cycle_cnt, retire_cnt, stall_cnt, mispred_cnt;

  int n_chk = 0;
  int n_err = 0;

  pipe_ctl #(.CNT_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .D_icode     (D_icode),
    .d_srcA      (d_srcA),
    .d_srcB      (d_srcB),
    .E_icode     (E_icode),
    .E_dstM      (E_dstM),
    .e_Cnd       (e_Cnd),
    .M_icode     (M_icode),
    .m_stat      (m_stat),
    .W_stat      (W_stat),
    .W_icode     (W_icode),
    .F_stall     (F_stall),
    .D_stall     (D_stall),
    .D_bubble    (D_bubble),
    .E_bubble    (E_bubble),
    .M_bubble    (M_bubble),
    .W_stall     (W_stall),
    .set_cc      (set_cc),
    .run_state   (run_state),
    .proc_stat   (proc_stat),
    .cycle_cnt   (cycle_cnt),
    .retire_cnt  (retire_cnt),
    .stall_cnt   (stall_cnt),
    .mispred_cnt (mispred_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Quiet pipeline: NOPs everywhere, all status AOK, no register dependencies.
  task automatic defaults();
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'h1; E_dstM = 4'hF; e_Cnd  = 1'b1;
    M_icode = 4'h1; m_stat = 4'h1; W_stat = 4'h1; W_icode = 4'h1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    defaults();

    // Reset state
    @(negedge clock); #1;
    check("rst_state", run_state, 0);
    check("rst_stat", proc_stat, 1);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_stall", stall_cnt, 0);
    reset = 1'b0; #1;
    check("idle_F_stall", F_stall, 1);
    check("idle_D_stall", D_stall, 0);
    check("idle_D_bubble", D_bubble, 1);
    check("idle_E_bubble", E_bubble, 1);
    check("idle_M_bubble", M_bubble, 1);
    check("idle_W_stall", W_stall, 0);

    // IDLE -> RUN
    start = 1'b1;
    @(negedge clock); start = 1'b0; #1;
    check("run_entered", run_state, 1);
    check("run_cycle0", cycle_cnt, 0);

    // c1: load/use on srcA
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
    check("lu_F_stall", F_stall, 1);
    check("lu_D_stall", D_stall, 1);
    check("lu_E_bubble", E_bubble, 1);
    check("lu_D_bubble", D_bubble, 0);
    check("lu_set_cc", set_cc, 0);

    // c2: RET in D
    @(negedge clock); defaults(); #1;
    check("lu_stall_cnt", stall_cnt, 1);
    check("lu_cycle_cnt", cycle_cnt, 1);
    D_icode = 4'h9; #1;
    check("retD_F_stall", F_stall, 1);
    check("retD_D_bubble", D_bubble, 1);
    check("retD_D_stall", D_stall, 0);
    check("retD_E_bubble", E_bubble, 0);
    // c3: RET in E
    @(negedge clock); defaults(); E_icode = 4'h9; #1;
    check("retE_D_bubble", D_bubble, 1);
    check("retE_F_stall", F_stall, 1);
    // c4: RET in M
    @(negedge clock); defaults(); M_icode = 4'h9; #1;
    check("retM_D_bubble", D_bubble, 1);
    // c5: mispredicted jump
    @(negedge clock); defaults(); #1;
    check("ret_stall_cnt", stall_cnt, 4);
    check("ret_done_D_bubble", D_bubble, 0);
    E_icode = 4'h7; e_Cnd = 1'b0; #1;
    check("mp_D_bubble", D_bubble, 1);
    check("mp_E_bubble", E_bubble, 1);
    check("mp_F_stall", F_stall, 0);
    // c6: taken jump
    @(negedge clock); defaults(); E_icode = 4'h7; e_Cnd = 1'b1; #1;
    check("mp_cnt", mispred_cnt, 1);
    check("tk_E_bubble", E_bubble, 0);
    check("tk_D_bubble", D_bubble, 0);
    // c7: OPq in E, OPq retiring
    @(negedge clock); defaults(); E_icode = 4'h6; W_icode = 4'h6; #1;
    check("tk_mp_cnt", mispred_cnt, 1);
    check("op_set_cc", set_cc, 1);
    check("op_M_bubble", M_bubble, 0);
    // c8: another retire
    @(negedge clock); defaults(); W_icode = 4'h6; #1;
    check("retire_1", retire_cnt, 1);
    // c9: memory exception with OPq in E
    @(negedge clock); defaults(); m_stat = 4'h3; E_icode = 4'h6; #1;
    check("retire_2", retire_cnt, 2);
    check("mexc_set_cc", set_cc, 0);
    check("mexc_M_bubble", M_bubble, 1);
    check("mexc_W_stall", W_stall, 0);
    // c10: exception reaches W
    @(negedge clock); defaults(); W_stat = 4'h3; W_icode = 4'h6; #1;
    check("wexc_W_stall", W_stall, 1);
    check("wexc_M_bubble", M_bubble, 1);
    check("wexc_state", run_state, 1);

    // STOP: frozen, inputs that would count in RUN are ignored
    @(negedge clock); E_icode = 4'h7; e_Cnd = 1'b0; #1;
    check("stop_state", run_state, 2);
    check("stop_stat", proc_stat, 3);
    check("stop_cycle", cycle_cnt, 10);
    check("stop_retire", retire_cnt, 2);
    check("stop_F_stall", F_stall, 1);
    check("stop_D_stall", D_stall, 1);
    check("stop_W_stall", W_stall, 1);
    check("stop_D_bubble", D_bubble, 0);
    check("stop_E_bubble", E_bubble, 1);
    check("stop_set_cc", set_cc, 0);
    @(negedge clock); #1;
    check("stop_cycle_hold", cycle_cnt, 10);
    check("stop_mp_hold", mispred_cnt, 1);

    // STOP -> IDLE
    defaults(); start = 1'b1;
    @(negedge clock); start = 1'b0; #1;
    check("s2i_state", run_state, 0);
    check("s2i_stat", proc_stat, 1);
    check("s2i_cycle_hold", cycle_cnt, 10);
    check("s2i_stall_hold", stall_cnt, 4);

    // IDLE -> RUN clears counters
    start = 1'b1;
    @(negedge clock); start = 1'b0; #1;
    check("rerun_state", run_state, 1);
    check("rerun_cycle", cycle_cnt, 0);
    check("rerun_retire", retire_cnt, 0);
    check("rerun_stall", stall_cnt, 0);
    check("rerun_mp", mispred_cnt, 0);

    // Ten quiet RUN cycles, with a start pulse that must be ignored
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      @(negedge clock);
    end
    start = 1'b0; #1;
    check("run10_state", run_state, 1);
    check("run10_cycle", cycle_cnt, 10);

    // Asynchronous reset mid-cycle, no clock edge in between
    #2 reset = 1'b1; #1;
    check("areset_state", run_state, 0);
    check("areset_F_stall", F_stall, 1);
    check("areset_cycle", cycle_cnt, 0);
    check("areset_stat", proc_stat, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
